// File: rtl/cpu_pkg.sv
// Shared RV32 pipeline definitions: ALU op and funct codes for the
// M extension plus the multiply/divide FSM state type.
package cpu_pkg;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_core.sv
// Radix-2 multiply/divide datapath: shift-add multiply, restoring divide.
// Ports: start_i loads operands, step_i runs one step, result_o = final value.
module muldiv_core
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  logic [2:0]      op_q;
  logic [XLEN-1:0] acc_hi_q;
  logic [XLEN-1:0] acc_lo_q;
  logic [XLEN-1:0] dvs_q;
  logic            neg_q;
  logic            sgn_a_q;
  logic            div0_q;

  logic            sgn_a;
  logic            sgn_b;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;

  always_comb begin
    sgn_a = a_i[XLEN-1] &&
      (op_i inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
    sgn_b = b_i[XLEN-1] &&
      (op_i inside {F3_MULH, F3_DIV, F3_REM});
    // -0x80000000 wraps to itself, which is the right unsigned magnitude
    abs_a = sgn_a ? -a_i : a_i;
    abs_b = sgn_b ? -b_i : b_i;
  end

  logic [XLEN:0]   sum;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] nxt_hi;
  logic [XLEN-1:0] nxt_lo;

  always_comb begin
    sum    = '0;
    trial  = '0;
    nxt_hi = acc_hi_q;
    nxt_lo = acc_lo_q;
    if (op_q[2]) begin
      // {rem, quo} shift left; 33-bit trial since divisor may exceed 2^31
      trial = {acc_hi_q, acc_lo_q[XLEN-1]};
      if (trial >= {1'b0, dvs_q}) begin
        nxt_hi = trial[XLEN-1:0] - dvs_q;
        nxt_lo = {acc_lo_q[XLEN-2:0], 1'b1};
      end else begin
        nxt_hi = trial[XLEN-1:0];
        nxt_lo = {acc_lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      sum    = {1'b0, acc_hi_q} +
               (acc_lo_q[0] ? {1'b0, dvs_q} : '0);
      nxt_hi = sum[XLEN:1];
      nxt_lo = {sum[0], acc_lo_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  // Evaluated on the post-step values so the top can register it
  // on the same edge as the final step.
  always_comb begin
    prod = {nxt_hi, nxt_lo};
    if (neg_q) prod = -prod;
    quo = div0_q ? '1 : (neg_q ? -nxt_lo : nxt_lo);
    rem = sgn_a_q ? -nxt_hi : nxt_hi;
    unique case (op_q)
      F3_MUL:                       result_o = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result_o = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              result_o = quo;
      default:                      result_o = rem;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      sgn_a_q  <= 1'b0;
      div0_q   <= 1'b0;
    end else if (start_i) begin
      op_q     <= op_i;
      acc_hi_q <= '0;
      acc_lo_q <= op_i[2] ? abs_a : abs_b;
      dvs_q    <= op_i[2] ? abs_b : abs_a;
      neg_q    <= sgn_a ^ sgn_b;
      sgn_a_q  <= sgn_a;
      div0_q   <= (b_i == '0);
    end else if (step_i) begin
      acc_hi_q <= nxt_hi;
      acc_lo_q <= nxt_lo;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage RV32M unit: decodes ID/EX, stalls the front end for 33 cycles,
// then pulses result_valid_o with result_o/RDaddr_o/RegWrite_o registered.
module ex_muldiv
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      ALUOp_i,
  input  logic            RegWrite_i,
  input  logic [9:0]      funct_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  input  logic [4:0]      RDaddr_i,
  output logic            stall_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      RDaddr_o,
  output logic            RegWrite_o
);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       rd_q;
  logic             we_q;
  logic             is_m;
  logic             start;
  logic             calc;
  logic             last;
  logic [XLEN-1:0]  core_res;

  assign is_m = (ALUOp_i == ALUOP_RTYPE) &&
                (funct_i[9:3] == FUNCT7_MEXT);

  always_comb begin
    state_d        = state_q;
    start          = 1'b0;
    calc           = 1'b0;
    last           = 1'b0;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        // rst_i gate keeps stall low while reset holds a live M op
        if (is_m && rst_i) begin
          start   = 1'b1;
          stall_o = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        calc    = 1'b1;
        stall_o = 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        result_valid_o = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start),
    .step_i   (calc),
    .op_i     (funct_i[2:0]),
    .a_i      (data1_i),
    .b_i      (data2_i),
    .result_o (core_res)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      result_o   <= '0;
      RDaddr_o   <= '0;
      RegWrite_o <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (calc && !last) ? cnt_q + 1'b1 : '0;
      if (start) begin
        rd_q <= RDaddr_i;
        we_q <= RegWrite_i;
      end
      if (last) begin
        result_o   <= core_res;
        RDaddr_o   <= rd_q;
        RegWrite_o <= we_q;
      end
    end
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Execute-stage iterative multiply/divide unit for the RV32 5-stage pipeline. It consumes the ID/EX pipeline register outputs directly: control, funct, forwarded operands and RD address. When the ID/EX slot holds an RV32M instruction, it stalls the front of the pipeline until the result is ready. It then presents the result to the EX/MEM write path alongside the ALU result.

Parameters:
XLEN, 32, operand/result width (only 32 is supported)
CNT_W, 6, iteration counter width; must be at least clog2(XLEN)+1

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-low reset
ALUOp_i  input  2  from ID/EX; 2'b10 = R-type
RegWrite_i  input  1  from ID/EX
funct_i  input  10  from ID/EX; [9:3]=funct7, [2:0]=funct3
data1_i  input  32  rs1 value after forwarding mux
data2_i  input  32  rs2 value after forwarding mux
RDaddr_i  input  5  from ID/EX
stall_o  output  1  freeze PC, IF/ID, ID/EX while high
result_valid_o  output  1  one-cycle pulse; result_o selected over ALU result
result_o  output  32  M-extension result
RDaddr_o  output  5  destination of completed op
RegWrite_o  output  1  RegWrite of completed op

Behaviour:
- Decode: is_m = (ALUOp_i==2'b10) && (funct_i[9:3]==7'b0000001). funct3 selects the op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If is_m is true, stall_o=1 combinationally in the same cycle.
  - Latch op, |data1|, |data2| and the result sign. Signed operands are signed per op; MULHSU treats only rs1 as signed.
  - Latch RDaddr_i and RegWrite_i. Go to CALC with cnt=0.
- CALC: one radix-2 step per cycle, 32 cycles (cnt 0..31), stall_o=1.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring, 32-bit remainder and quotient.
  - After cnt==31, go to DONE.
- DONE:
  - stall_o=0 and result_valid_o=1 for exactly one cycle.
  - result_o = sign-corrected result: low 32 bits for MUL; high 32 bits for MULH/MULHSU/MULHU; quotient or remainder for divides.
  - Always return to IDLE. The start condition is ignored in DONE, because ID/EX still holds the same instruction until this edge.
- Latency: an M instruction in ID/EX at cycle T sets stall_o high for T..T+32 (33 cycles). result_valid_o pulses at T+33.
- result_o, RDaddr_o and RegWrite_o are registered and hold their value until the next DONE. They are meaningful only while result_valid_o is high.
- Signed division sign rules: the remainder takes the sign of the dividend; the quotient is negative iff the operand signs differ. The 64-bit product is negated when the result sign is negative.
- Division by zero (no trap, fixed latency kept):
  - DIV/DIVU: quotient = 0xFFFFFFFF.
  - REM/REMU: remainder = dividend.
- Signed overflow, 0x80000000 / -1: DIV = 0x80000000, REM = 0.
- Abs of 0x80000000 is 0x80000000 treated as unsigned; this must be correct for both MULH and DIV.
- Non-M instructions, and bubbles (ALUOp=00): stall_o=0, result_valid_o=0, and the FSM stays in IDLE.
- Back-to-back M ops: the second op is accepted in the IDLE cycle right after DONE.
- Reset (asynchronous, mid-operation included):
  - FSM returns to IDLE and cnt=0.
  - stall_o=0 and result_valid_o=0.
  - result_o=0, RDaddr_o=0, RegWrite_o=0.
  - All datapath registers are cleared.

Decomposition:
- Shared package cpu_pkg holds:
  - ALUOP_RTYPE = 2'b10 and FUNCT7_MEXT = 7'b0000001.
  - The eight funct3 M-op constants.
  - The muldiv_state_t enum (IDLE/CALC/DONE).
- One sub-module, muldiv_core: owns the accumulator, remainder and quotient shift registers and the per-cycle step, plus the final sign correction. ex_muldiv keeps the decode, the FSM, stall generation and the output registers.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD at T: stall_o high T..T+32; result_valid_o at T+33 with result_o=0xFFFFFFEB, RDaddr_o and RegWrite_o echoed.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM of the same -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Corner cases: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. Each still takes 33 stall cycles.
- Back-to-back MUL then DIV: two separate 33-cycle stalls and two result pulses, with the DIV accepted the cycle after the first DONE. An ADD (funct7=0) and a bubble both give stall_o=0 throughout.
- Drop rst_i low asynchronously at T+10 of a DIV: stall_o, result_valid_o and result_o go to 0 immediately. After release the FSM is IDLE and a new MUL completes normally.
